// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter: round-robin arbiter sharing the pwm APB register port among NREQ requesters.
// Optional ACCESS-phase timeout is built only when PWM_ARB_TIMEOUT_EN is defined.
module pwm_reg_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TMO_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_write_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [DW-1:0]     rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              write_o,
  output logic [AW-1:0]     addr_o,
  output logic [DW-1:0]     wdata_o,
  input  logic [DW-1:0]     rdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   gnt_q;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            tmo_hit;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Descending scan so the requester closest to rr_ptr (lowest offset) is the final winner.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid_i[wrap_add(rr_ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_ptr_q, i);
      end
    end
  end

`ifdef PWM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC) + 1;
  logic [CW-1:0] tmo_cnt_q;

  assign tmo_hit = !pready_i && (tmo_cnt_q == CW'(TMO_CYC - 1));

  // Cleared during SETUP so it reads 0 on the first ACCESS cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !pready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // No timeout path: ACCESS waits for pready indefinitely.
  assign tmo_hit = (TMO_CYC < 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pick_vld) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready_i || tmo_hit) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick_idx;
            write_q <= req_write_i[pick_idx];
            addr_q  <= req_addr_i[pick_idx*AW +: AW];
            wdata_q <= req_wdata_i[pick_idx*DW +: DW];
          end
        end
        S_ACCESS: begin
          if (pready_i) begin
            rdata_q <= write_q ? '0 : rdata_i;
            err_q   <= pslverr_i;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RESP:  rr_ptr_q <= wrap_add(gnt_q, 1);
        default: ;
      endcase
    end
  end

  // Handshake: req_valid_i[k] is held with stable fields until req_ready_o[k] pulses for one
  // cycle (accepted at that clock edge); rsp_valid_o[k] is a one-cycle pulse with no back-pressure.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (state_q == S_IDLE && pick_vld && !rst_i) begin
      req_ready_o = NREQ'(1) << pick_idx;
    end
    if (state_q == S_RESP) begin
      rsp_valid_o = NREQ'(1) << gnt_q;
      rsp_rdata_o = rdata_q;
      rsp_err_o   = err_q;
    end
  end

  assign psel_o      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o   = (state_q == S_ACCESS);
  assign write_o     = psel_o & write_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Bench for pwm_reg_arbiter: requester queues, behavioural APB slave, transaction-level model
// with a per-cycle compare process, plus directed literal checks of the documented scenarios.
module tb_pwm_reg_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TMO_CYC = 16;
  localparam int EW = NREQ + 1 + DW;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [NREQ-1:0] req_valid_i, req_write_i, req_ready_o, rsp_valid_o;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_wdata_i;
  logic [DW-1:0] rsp_rdata_o, wdata_o;
  logic rsp_err_o, psel_o, penable_o, write_o, busy_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] rdata_i = '0;
  logic pready_i = 1'b0;
  logic pslverr_i = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pwm_reg_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO_CYC(TMO_CYC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .write_o(write_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .busy_o(busy_o),
    .dbg_state_o(dbg_state)
  );

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- requesters: per-requester transaction lists ----------------
  int head[NREQ] = '{default: 0};
  int tail[NREQ] = '{default: 0};
  logic          tq_w[NREQ][16];
  logic [AW-1:0] tq_a[NREQ][16];
  logic [DW-1:0] tq_d[NREQ][16];
  logic [NREQ-1:0] acc_seen = '0;

  for (genvar k = 0; k < NREQ; k++) begin : g_drv
    assign req_valid_i[k]          = (head[k] != tail[k]);
    assign req_write_i[k]          = tq_w[k][head[k]];
    assign req_addr_i[k*AW +: AW]  = tq_a[k][head[k]];
    assign req_wdata_i[k*DW +: DW] = tq_d[k][head[k]];
  end

  task automatic post(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tq_w[k][tail[k]] = w;
    tq_a[k][tail[k]] = a;
    tq_d[k][tail[k]] = d;
    tail[k]++;
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NREQ; k++) if (acc_seen[k]) head[k]++;
  end

  // ---------------- APB slave: pready after wait_cfg ACCESS cycles ----------------
  int wait_cfg = 0;
  int s_cnt = 0;
  logic [AW-1:0] err_addr = 8'hFF;
  logic [DW-1:0] slv_mem[256];
  logic [DW-1:0] mdl_mem[256];

  always @(posedge clk) begin
    #2;
    if (psel_o && penable_o) begin
      if (s_cnt == wait_cfg) begin
        pready_i  = 1'b1;
        pslverr_i = (addr_o == err_addr);
        rdata_i   = slv_mem[addr_o];
        if (write_o && !pslverr_i) slv_mem[addr_o] = wdata_o;
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        rdata_i   = 32'hBAD0_0000 | s_cnt;
      end
      s_cnt++;
    end else begin
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      rdata_i   = 32'hBAD0_BAD0;
      s_cnt     = 0;
    end
  end

  // ---------------- transaction-level model and per-cycle compare ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int m_act = 0, m_t0 = 0, m_g = 0, m_w = 0, m_ptr = 0;
  logic m_wr, m_err, m_to;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd;
  int k_rel, g;

  always @(negedge clk) begin
    acc_seen = req_ready_o;
    if (rst_i) begin
      m_act = 0;
      m_ptr = 0;
      exp_q.delete();
    end else if (m_act != 0) begin
      k_rel = cyc - m_t0;
      chk("ready_when_busy", req_ready_o, 0);
      chk("busy", busy_o, 1);
      chk("psel", psel_o, k_rel <= 2 + m_w);
      chk("penable", penable_o, (k_rel >= 2) && (k_rel <= 2 + m_w));
      if (k_rel <= 2 + m_w) begin
        chk("addr", addr_o, m_a);
        chk("wdata", wdata_o, m_d);
        chk("write", write_o, m_wr);
      end else begin
        chk("write_idle", write_o, 0);
      end
      if (k_rel == 3 + m_w) begin
        e = exp_q.pop_front();
        chk("rsp_valid", rsp_valid_o, e[EW-1 -: NREQ]);
        chk("rsp_err", rsp_err_o, e[DW]);
        chk("rsp_rdata", rsp_rdata_o, e[DW-1:0]);
        m_ptr = (m_g + 1) % NREQ;
        m_act = 0;
      end else begin
        chk("rsp_valid_quiet", rsp_valid_o, 0);
      end
    end else begin
      g = -1;
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && req_valid_i[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      chk("ready", req_ready_o, (g < 0) ? 0 : (1 << g));
      chk("idle_psel", psel_o, 0);
      chk("idle_penable", penable_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_rsp", rsp_valid_o, 0);
      chk("idle_write", write_o, 0);
      if (g >= 0) begin
        m_act = 1;
        m_t0  = cyc;
        m_g   = g;
        m_wr  = req_write_i[g];
        m_a   = req_addr_i[g*AW +: AW];
        m_d   = req_wdata_i[g*DW +: DW];
        m_w   = wait_cfg;
        m_to  = 1'b0;
`ifdef PWM_ARB_TIMEOUT_EN
        if (m_w > TMO_CYC - 1) begin
          m_w  = TMO_CYC - 1;
          m_to = 1'b1;
        end
`endif
        m_err = m_to || (m_a == err_addr);
        m_rd  = (m_to || m_wr) ? '0 : mdl_mem[m_a];
        if (m_wr && !m_err) mdl_mem[m_a] = m_d;
        exp_q.push_back({NREQ'(1 << g), m_err, m_rd});
      end
    end
  end

  // ---------------- directed scenarios ----------------
  int np;
  int pc[8];
  logic [NREQ-1:0] pv[8];
  logic [DW-1:0] pd[8];
  int pen_cnt, rsp_at;
  logic rsp_err_seen;
  logic [DW-1:0] rsp_rd_seen;
  logic [NREQ-1:0] rr_ord[6];
  logic [DW-1:0] rr_dat[6];

  initial begin
    for (int a = 0; a < 256; a++) begin
      slv_mem[a] = a * 25;
      mdl_mem[a] = a * 25;
    end
    rr_ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_dat = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h0, 32'h33};
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_psel", psel_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_rsp", rsp_valid_o, 0);

    // single write, zero-wait slave
    @(posedge clk); #1 post(0, 1'b1, 8'h0C, 32'h94);
    @(negedge clk); chk("w_ready", req_ready_o, 3'b001);
    @(negedge clk); chk("w_setup_psel", psel_o, 1); chk("w_setup_pen", penable_o, 0);
    chk("w_addr", addr_o, 8'h0C); chk("w_wdata", wdata_o, 32'h94); chk("w_write", write_o, 1);
    @(negedge clk); chk("w_acc_pen", penable_o, 1);
    @(negedge clk); chk("w_rsp", rsp_valid_o, 3'b001); chk("w_err", rsp_err_o, 0);
    @(negedge clk); chk("w_done_busy", busy_o, 0);

    // read with two wait states
    wait_cfg = 2;
    @(posedge clk); #1 post(1, 1'b0, 8'h08, 32'h0);
    @(negedge clk); chk("r_ready", req_ready_o, 3'b010);
    repeat (4) @(negedge clk);
    chk("r_pen_3rd", penable_o, 1);
    @(negedge clk); chk("r_rsp", rsp_valid_o, 3'b010); chk("r_rdata", rsp_rdata_o, 32'd200);
    chk("r_pen_off", penable_o, 0);
    @(negedge clk);

    // slave error on a write
    wait_cfg = 0;
    err_addr = 8'h04;
    @(posedge clk); #1 post(2, 1'b1, 8'h04, 32'h55);
    @(negedge clk); chk("e_ready", req_ready_o, 3'b100);
    repeat (3) @(negedge clk);
    chk("e_rsp", rsp_valid_o, 3'b100); chk("e_err", rsp_err_o, 1);
    @(negedge clk);
    err_addr = 8'hFF;

    // round robin, all three requesting continuously
    @(posedge clk); #1;
    post(0, 1'b1, 8'h10, 32'h11); post(1, 1'b0, 8'h10, 32'h0); post(2, 1'b1, 8'h20, 32'h22);
    post(0, 1'b0, 8'h20, 32'h0);  post(1, 1'b1, 8'h10, 32'h33); post(2, 1'b0, 8'h10, 32'h0);
    np = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (rsp_valid_o != '0 && np < 8) begin
        pv[np] = rsp_valid_o; pd[np] = rsp_rdata_o; pc[np] = cyc; np++;
      end
    end
    chk("rr_count", np, 6);
    for (int i = 0; i < 6 && i < np; i++) begin
      chk("rr_order", pv[i], rr_ord[i]);
      chk("rr_rdata", pd[i], rr_dat[i]);
      if (i > 0) chk("rr_spacing", pc[i] - pc[i-1], 4);
    end

    // reset in the middle of ACCESS
    wait_cfg = 1000;
    @(posedge clk); #1 post(1, 1'b0, 8'h08, 32'h0);
    repeat (3) @(negedge clk);
    chk("x_in_access", penable_o, 1);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    wait_cfg = 0;
    post(0, 1'b0, 8'h0C, 32'h0); post(1, 1'b0, 8'h08, 32'h0);
    @(negedge clk);
    chk("x_psel", psel_o, 0); chk("x_busy", busy_o, 0); chk("x_rsp", rsp_valid_o, 0);
    chk("x_first_req0", req_ready_o, 3'b001);
    repeat (3) @(negedge clk);
    chk("x_rsp0", rsp_valid_o, 3'b001); chk("x_rdata", rsp_rdata_o, 32'h94);
    repeat (5) @(negedge clk);

    // slave never ready
    wait_cfg = 1000;
    @(posedge clk); #1 post(2, 1'b0, 8'h0C, 32'h0);
    pen_cnt = 0; rsp_at = -1; rsp_err_seen = 1'b0; rsp_rd_seen = 'x;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (penable_o) pen_cnt++;
      if (rsp_valid_o != '0) begin
        rsp_at = i; rsp_err_seen = rsp_err_o; rsp_rd_seen = rsp_rdata_o;
      end
    end
`ifdef PWM_ARB_TIMEOUT_EN
    chk("t_access_cycles", pen_cnt, 16);
    chk("t_rsp_cycle", rsp_at, 18);
    chk("t_err", rsp_err_seen, 1);
    chk("t_rdata", rsp_rd_seen, 0);
`else
    chk("t_access_cycles", pen_cnt, 22);
    chk("t_no_rsp", rsp_at, -1);
    chk("t_busy", busy_o, 1);
`endif
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    chk("t_after_rst_busy", busy_o, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_reg_arbiter.md
Name: pwm_reg_arbiter

Overview:
- Shares the single APB-style register port of the pwm peripheral among NREQ independent requesters, e.g. the speed/duty sequencer, the enable/ctrl sequencer and a host/debug port.
- Each requester posts one register read or write. The block picks a winner round-robin, runs a two-phase APB transfer (SETUP then ACCESS), waits for pready and returns rdata/error to the winner only.
- Sits between the configuration controllers and the pwm instance; it is the only driver of psel/penable/write/addr/wdata.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 8, register address width
- DW, 32, register data width
- TMO_CYC, 16, max ACCESS cycles waiting for pready before abort (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  NREQ  request pending, one bit per requester
- req_write_i  in  NREQ  1=write, 0=read
- req_addr_i  in  NREQ*AW  packed addresses; requester k at [k*AW +: AW]
- req_wdata_i  in  NREQ*DW  packed write data; requester k at [k*DW +: DW]
- req_ready_o  out  NREQ  one-hot, 1-cycle pulse: request accepted
- rsp_valid_o  out  NREQ  one-hot, 1-cycle pulse: transfer complete
- rsp_rdata_o  out  DW  read data, valid with rsp_valid_o
- rsp_err_o  out  1  slave error or timeout, valid with rsp_valid_o
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- write_o  out  1  APB direction
- addr_o  out  AW  APB address
- wdata_o  out  DW  APB write data
- rdata_i  in  DW  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high; all state updates on the rising edge of clk_i.
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid_i bit is set, grant the first set bit searching from rr_ptr upward with wrap-around.
  - Same cycle: drive req_ready_o[g]=1 (combinational from registered state plus req_valid_i).
  - At the clock edge: latch g, write, addr and wdata; go to SETUP.
  - Requester g must hold its request fields stable until the req_ready pulse; it may drop or change them after.
- SETUP: psel_o=1, penable_o=0, addr/wdata/write driven from the latched values; always 1 cycle, then ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1, bus fields unchanged.
  - Stay while pready_i=0.
  - On pready_i=1: capture rdata_i (reads only; writes capture 0) and pslverr_i; go to RESP.
- RESP:
  - psel_o=0, penable_o=0; rsp_valid_o[g]=1 for exactly 1 cycle, with captured rsp_rdata_o/rsp_err_o.
  - rr_ptr <= (g+1) mod NREQ; go to IDLE.
- Outside SETUP/ACCESS: psel_o=penable_o=write_o=0; addr_o/wdata_o hold their last value.
- Latency with zero-wait slave: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3. One transfer per 4 cycles max.
- Arbitration:
  - Strictly fair; no requester waits more than NREQ-1 grants.
  - Requests arriving while busy_o=1 are held by the requester; nothing is queued inside the block.
- Simultaneous events: a req_valid_i change during SETUP/ACCESS/RESP has no effect on the current transfer.
- Reset mid-transfer (any state): bus is idle the next cycle (psel_o=0) and no rsp_valid is issued. The interrupted requester gets no response and must re-request.
- Requester index outside 0..NREQ-1: cannot occur; unused mask bits are ignored.

Optional Feature:
- Macro: PWM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When it reaches TMO_CYC-1 with pready_i still 0, go to RESP with rsp_err_o=1 and rsp_rdata_o=0. psel_o drops in RESP.
- Undefined: no counter is built; ACCESS waits for pready_i indefinitely and TMO_CYC is unused.

Test Plan:
- Single write: req0 write addr=0x0C wdata=0x94, pready tied 1 -> psel at cycles 1-2, penable at cycle 2, addr_o=0x0C, wdata_o=0x94; rsp_valid_o=3'b001 at cycle 3 with rsp_err_o=0.
- Read with wait states: req1 read addr=0x08, pready asserted on the 3rd ACCESS cycle, rdata_i=200 -> penable high 3 cycles; rsp_valid_o=3'b010 with rsp_rdata_o=200.
- Round-robin: all three request continuously -> grant order 0,1,2,0,1,2; six rsp_valid pulses spaced 4 cycles apart.
- Slave error: pslverr_i=1 together with pready on a write to addr=0x04 -> rsp_err_o=1 with the response pulse; next grant proceeds normally.
- Reset mid-ACCESS: assert rst_i for 1 cycle while pready=0 -> next cycle psel_o=0, busy_o=0, no rsp_valid; rr_ptr=0 so req0 is granted first afterwards.
- With PWM_ARB_TIMEOUT_EN and TMO_CYC=16: pready stuck 0 -> 16 ACCESS cycles, then rsp_valid with rsp_err_o=1 and rsp_rdata_o=0. Without the macro, the block remains in ACCESS with busy_o=1.
